// File: rtl/c432_stim_pkg.sv
// Shared constants, state encoding and helpers for the c432 stimulus driver.
package c432_stim_pkg;

    localparam int NUM_IN  = 36;
    localparam int NUM_OUT = 7;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    // Feedback taps of the x^36 + x^25 + 1 vector LFSR.
    localparam int LFSR_TAP_HI = 35;
    localparam int LFSR_TAP_LO = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // One LFSR step: shift toward the top bit, feed the tap XOR into bit 0.
    function automatic logic [NUM_IN-1:0] lfsr_next(input logic [NUM_IN-1:0] v);
        return {v[NUM_IN-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

    // Reload value of the toggle counter for bit i (half-period 36-i, minus one).
    function automatic logic [5:0] tog_reload(input int i);
        return 6'(NUM_IN - 1 - i);
    endfunction

endpackage

// File: rtl/c432_stim_drv_if.sv
// Control, stimulus and response bundle between the driver and its user/harness.
interface c432_stim_drv_if;
    import c432_stim_pkg::*;

    logic                start;
    logic                mode;
    logic [NUM_IN-1:0]   seed;
    logic [NUM_IN-1:0]   vec_out;
    logic                vec_valid;
    logic [NUM_OUT-1:0]  resp_in;
    logic                busy;
    logic                done;
    logic [15:0]         signature;
    logic [15:0]         vec_count;
    logic                pass;

    // Driver side.
    modport master (
        input  start, mode, seed, resp_in,
        output vec_out, vec_valid, busy, done, signature, vec_count, pass
    );

    // Controller / harness side.
    modport slave (
        output start, mode, seed, resp_in,
        input  vec_out, vec_valid, busy, done, signature, vec_count, pass
    );

endinterface

// File: rtl/c432_misr.sv
// 16-bit MISR folding a 7-bit response word per enabled cycle (poly 0x1021).
module c432_misr
    import c432_stim_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [NUM_OUT-1:0] i_data,
    output logic [15:0]        o_sig
);

    logic [15:0] r_sig;
    logic [15:0] w_sig_next;

    // Next signature: shift, conditional polynomial feedback, XOR in the response.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        w_sig_next = {r_sig[14:0], 1'b0}
                   ^ (r_sig[15] ? MISR_POLY : 16'h0000)
                   ^ {{(16 - NUM_OUT){1'b0}}, i_data};
    end

    // Signature register: clear has priority over absorbing a response.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= w_sig_next;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/c432_stim_drv.sv
// Stimulus transmitter and response compactor for the registered c432 harness.
// Issues NUM_VEC vectors (toggle-divider or LFSR), tracks the PIPE_LAT-deep
// harness pipeline and folds the responses into a 16-bit MISR signature.
// Optional golden-signature comparator: define C432_STIM_DRV_GOLDEN_EN.
module c432_stim_drv
    import c432_stim_pkg::*;
#(
    parameter int                NUM_VEC    = 2048,
    parameter int                PIPE_LAT   = 2,
    parameter logic [NUM_IN-1:0] SEED_DFLT  = 36'hF_FFFF_FFFF
`ifdef C432_STIM_DRV_GOLDEN_EN
    ,
    parameter logic [15:0]       GOLDEN_SIG = 16'h0000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    c432_stim_drv_if.master  bus
);

    localparam logic [15:0] NUM_VEC_W = 16'(NUM_VEC);

    state_t              r_state;
    logic                r_mode;
    logic [NUM_IN-1:0]   r_vec;
    logic                r_vec_valid;
    logic [15:0]         r_vec_count;
    logic [PIPE_LAT-1:0] r_pipe;
    logic                r_done;
    logic [5:0]          r_tcnt [NUM_IN];

    logic                w_start;
    logic                w_step;
    logic [PIPE_LAT-1:0] w_pipe_next;
    logic [NUM_IN-1:0]   w_seed0;
    logic [NUM_IN-1:0]   w_tog_vec;
    logic [5:0]          w_tcnt_next [NUM_IN];
    logic [15:0]         w_sig;

    // Start is only honoured from IDLE; a step presents the next vector in RUN.
    assign w_start     = (r_state == IDLE) && bus.start;
    assign w_step      = (r_state == RUN) && (r_vec_count < NUM_VEC_W);
    assign w_pipe_next = PIPE_LAT'({r_pipe, r_vec_valid});
    assign w_seed0     = (bus.seed == '0) ? SEED_DFLT : bus.seed;

    // Toggle-divider next vector: a bit flips when its half-period counter expires.
    always_comb begin
        w_tog_vec = r_vec;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_tcnt[i] == 6'd0) begin
                w_tog_vec[i]   = ~r_vec[i];
                w_tcnt_next[i] = tog_reload(i);
            end else begin
                w_tcnt_next[i] = r_tcnt[i] - 6'd1;
            end
        end
    end

    // Half-period counters: loaded on start, advanced with each new vector.
    always_ff @(posedge clk) begin
        // NOTE: this counter array has no reset; start reloads every entry before it is used.
        if (w_start) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_tcnt[i] <= tog_reload(i);
            end
        end else if (w_step) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_tcnt[i] <= w_tcnt_next[i];
            end
        end
    end

    // Run controller: IDLE -> RUN -> DRAIN -> DONE, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_vec_count <= '0;
            r_pipe      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_pipe <= w_pipe_next;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= RUN;
                        r_mode      <= bus.mode;
                        r_vec       <= bus.mode ? w_seed0 : '0;
                        r_vec_valid <= 1'b1;
                        r_vec_count <= 16'd1;
                    end
                end
                RUN: begin
                    if (w_step) begin
                        r_vec       <= r_mode ? lfsr_next(r_vec) : w_tog_vec;
                        r_vec_count <= r_vec_count + 16'd1;
                    end else begin
                        r_state     <= DRAIN;
                        r_vec_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The last response is absorbed on the same edge the pipe empties.
                    if (w_pipe_next == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_vec       <= '0;
                    r_vec_count <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    c432_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (r_pipe[PIPE_LAT-1]),
        .i_data (bus.resp_in),
        .o_sig  (w_sig)
    );

`ifdef C432_STIM_DRV_GOLDEN_EN
    logic r_pass;

    // Golden comparison on the DONE edge; held until the next start or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (w_start) begin
            r_pass <= 1'b0;
        end else if (r_state == DONE) begin
            r_pass <= (w_sig == GOLDEN_SIG);
        end
    end

    assign bus.pass = r_pass;
`else
    assign bus.pass = 1'b0;
`endif

    assign bus.vec_out   = r_vec;
    assign bus.vec_valid = r_vec_valid;
    assign bus.busy      = (r_state == RUN) || (r_state == DRAIN);
    assign bus.done      = r_done;
    assign bus.signature = w_sig;
    assign bus.vec_count = r_vec_count;

endmodule

// File: tb/tb_c432_stim_drv.sv
// Directed bench for c432_stim_drv: three instances with NUM_VEC = 4, 2, 1.
module tb_c432_stim_drv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    c432_stim_drv_if if4 ();
    c432_stim_drv_if if2 ();
    c432_stim_drv_if if1 ();

    c432_stim_drv #(.NUM_VEC(4), .PIPE_LAT(2)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

`ifdef C432_STIM_DRV_GOLDEN_EN
    c432_stim_drv #(.NUM_VEC(2), .PIPE_LAT(2), .GOLDEN_SIG(16'h0003)) u_dut2 (
`else
    c432_stim_drv #(.NUM_VEC(2), .PIPE_LAT(2)) u_dut2 (
`endif
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    c432_stim_drv #(.NUM_VEC(1), .PIPE_LAT(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (if4.busy !== 1'b0 || if4.vec_valid !== 1'b0 || if4.done !== 1'b0 || if4.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl4: got busy=%b valid=%b done=%b pass=%b expected all 0",
                     if4.busy, if4.vec_valid, if4.done, if4.pass);
        end
        n_checks++;
        if (if4.vec_out !== 36'h0 || if4.signature !== 16'h0 || if4.vec_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data4: got vec=%h sig=%h cnt=%0d expected 0/0/0",
                     if4.vec_out, if4.signature, if4.vec_count);
        end
        n_checks++;
        if (if2.busy !== 1'b0 || if1.busy !== 1'b0 || if2.done !== 1'b0 || if1.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_other: got busy2=%b busy1=%b done2=%b done1=%b expected 0",
                     if2.busy, if1.busy, if2.done, if1.done);
        end
        rst = 1'b0;
    endtask

    // Toggle mode, NUM_VEC=4, resp=1: vectors 0,8..,4..,E.. and signature 1,3,7,F.
    task automatic test_toggle();
        logic [35:0] exp_vec [4];
        exp_vec[0] = 36'h0_0000_0000;
        exp_vec[1] = 36'h8_0000_0000;
        exp_vec[2] = 36'h4_0000_0000;
        exp_vec[3] = 36'hE_0000_0000;
        @(negedge clk);
        if4.mode = 1'b0; if4.resp_in = 7'h01; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (if4.vec_out !== exp_vec[k] || if4.vec_valid !== 1'b1 || if4.vec_count !== 16'(k + 1)
                || if4.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL toggle_vec%0d: got vec=%h valid=%b cnt=%0d busy=%b expected vec=%h valid=1 cnt=%0d busy=1",
                         k, if4.vec_out, if4.vec_valid, if4.vec_count, if4.busy, exp_vec[k], k + 1);
            end
            @(negedge clk);
        end
        n_checks++;
        if (if4.vec_valid !== 1'b0 || if4.vec_out !== 36'hE_0000_0000 || if4.vec_count !== 16'd4
            || if4.busy !== 1'b1 || if4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_drain: got valid=%b vec=%h cnt=%0d busy=%b done=%b expected 0/e00000000/4/1/0",
                     if4.vec_valid, if4.vec_out, if4.vec_count, if4.busy, if4.done);
        end
        @(negedge clk);
        n_checks++;
        if (if4.done !== 1'b0 || if4.signature !== 16'h0007) begin
            n_fail++;
            $display("FAIL toggle_e5: got done=%b sig=%h expected done=0 sig=0007", if4.done, if4.signature);
        end
        @(negedge clk);
        n_checks++;
        if (if4.done !== 1'b1 || if4.signature !== 16'h000F) begin
            n_fail++;
            $display("FAIL toggle_done: got done=%b sig=%h expected done=1 sig=000f", if4.done, if4.signature);
        end
        @(negedge clk);
        n_checks++;
        if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.signature !== 16'h000F) begin
            n_fail++;
            $display("FAIL toggle_after: got done=%b busy=%b sig=%h expected 0/0/000f",
                     if4.done, if4.busy, if4.signature);
        end
    endtask

    // LFSR with seed 1, resp=0; mode changes and a start press mid-run must not matter.
    task automatic test_busy_start();
        logic [35:0] exp_vec [4];
        int          extra_activity;
        exp_vec[0] = 36'h1;
        exp_vec[1] = 36'h2;
        exp_vec[2] = 36'h4;
        exp_vec[3] = 36'h8;
        extra_activity = 0;
        @(negedge clk);
        if4.mode = 1'b1; if4.seed = 36'h1; if4.resp_in = 7'h00; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0; if4.mode = 1'b0; if4.seed = 36'h0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (if4.vec_out !== exp_vec[k]) begin
                n_fail++;
                $display("FAIL lfsr1_vec%0d: got %h expected %h", k, if4.vec_out, exp_vec[k]);
            end
            if4.start = (k == 1);
            @(negedge clk);
        end
        if4.start = 1'b0;
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        n_checks++;
        if (if4.done !== 1'b1 || if4.signature !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_resp_done: got done=%b sig=%h expected done=1 sig=0000", if4.done, if4.signature);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if4.busy !== 1'b0 || if4.done !== 1'b0) extra_activity++;
        end
        n_checks++;
        if (extra_activity != 0) begin
            n_fail++;
            $display("FAIL start_while_busy: got %0d busy/done cycles expected 0", extra_activity);
        end
    endtask

    // LFSR on the NUM_VEC=2 instance: default seed, then seed 1 with a different response.
    task automatic test_lfsr();
        @(negedge clk);
        if2.mode = 1'b1; if2.seed = 36'h0; if2.resp_in = 7'h01; if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        n_checks++;
        if (if2.vec_out !== 36'hF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL lfsr0_vec0: got %h expected fffffffff", if2.vec_out);
        end
        @(negedge clk);
        n_checks++;
        if (if2.vec_out !== 36'hF_FFFF_FFFE || if2.vec_count !== 16'd2) begin
            n_fail++;
            $display("FAIL lfsr0_vec1: got vec=%h cnt=%0d expected fffffffffe cnt=2", if2.vec_out, if2.vec_count);
        end
        @(negedge clk);
        n_checks++;
        if (if2.vec_valid !== 1'b0 || if2.vec_count !== 16'd2 || if2.vec_out !== 36'hF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL lfsr0_drain: got valid=%b cnt=%0d vec=%h expected 0/2/ffffffffe",
                     if2.vec_valid, if2.vec_count, if2.vec_out);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (if2.done !== 1'b1 || if2.signature !== 16'h0003) begin
            n_fail++;
            $display("FAIL n2_sig: got done=%b sig=%h expected done=1 sig=0003", if2.done, if2.signature);
        end
        @(negedge clk);
        n_checks++;
`ifdef C432_STIM_DRV_GOLDEN_EN
        if (if2.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL golden_pass: got %b expected 1", if2.pass);
        end
`else
        if (if2.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_tied: got %b expected 0", if2.pass);
        end
`endif
        if2.seed = 36'h1; if2.resp_in = 7'h02; if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        n_checks++;
        if (if2.vec_out !== 36'h1 || if2.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL lfsr1_start: got vec=%h pass=%b expected vec=1 pass=0", if2.vec_out, if2.pass);
        end
        @(negedge clk);
        n_checks++;
        if (if2.vec_out !== 36'h2) begin
            n_fail++;
            $display("FAIL lfsr1_vec1: got %h expected 2", if2.vec_out);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (if2.done !== 1'b1 || if2.signature !== 16'h0006) begin
            n_fail++;
            $display("FAIL n2_sig_r2: got done=%b sig=%h expected done=1 sig=0006", if2.done, if2.signature);
        end
        @(negedge clk);
        n_checks++;
        if (if2.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL golden_fail: got %b expected 0", if2.pass);
        end
    endtask

    // NUM_VEC=1: RUN lasts one cycle, done after edge e+3, signature 0001.
    task automatic test_single();
        @(negedge clk);
        if1.mode = 1'b0; if1.resp_in = 7'h01; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        n_checks++;
        if (if1.vec_valid !== 1'b1 || if1.busy !== 1'b1 || if1.vec_count !== 16'd1 || if1.vec_out !== 36'h0) begin
            n_fail++;
            $display("FAIL n1_run: got valid=%b busy=%b cnt=%0d vec=%h expected 1/1/1/0",
                     if1.vec_valid, if1.busy, if1.vec_count, if1.vec_out);
        end
        @(negedge clk);
        n_checks++;
        if (if1.vec_valid !== 1'b0 || if1.busy !== 1'b1 || if1.vec_count !== 16'd1) begin
            n_fail++;
            $display("FAIL n1_drain: got valid=%b busy=%b cnt=%0d expected 0/1/1",
                     if1.vec_valid, if1.busy, if1.vec_count);
        end
        @(negedge clk);
        n_checks++;
        if (if1.done !== 1'b0) begin
            n_fail++;
            $display("FAIL n1_early_done: got %b expected 0", if1.done);
        end
        @(negedge clk);
        n_checks++;
        if (if1.done !== 1'b1 || if1.signature !== 16'h0001) begin
            n_fail++;
            $display("FAIL n1_sig: got done=%b sig=%h expected done=1 sig=0001", if1.done, if1.signature);
        end
        @(negedge clk);
    endtask

    // Reset one cycle after vector 2's cycle aborts the run with no done pulse.
    task automatic test_reset_midrun();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        if4.mode = 1'b0; if4.resp_in = 7'h01; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (if4.signature !== 16'h0001 || if4.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre: got sig=%h busy=%b expected sig=0001 busy=1", if4.signature, if4.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if4.busy !== 1'b0 || if4.vec_valid !== 1'b0 || if4.signature !== 16'h0
            || if4.vec_count !== 16'h0 || if4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b valid=%b sig=%h cnt=%0d done=%b expected all 0",
                     if4.busy, if4.vec_valid, if4.signature, if4.vec_count, if4.done);
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if4.done !== 1'b0 || if4.busy !== 1'b0) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d active cycles expected 0", done_seen);
        end
    endtask

    // start and rst together: reset wins and no run begins.
    task automatic test_start_rst_same();
        @(negedge clk);
        rst = 1'b1; if4.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; if4.start = 1'b0;
        n_checks++;
        if (if4.busy !== 1'b0 || if4.vec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_rst: got busy=%b valid=%b expected 0/0", if4.busy, if4.vec_valid);
        end
        @(negedge clk);
        n_checks++;
        if (if4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_rst_after: got busy=%b expected 0", if4.busy);
        end
    endtask

    initial begin
        if4.start = 1'b0; if4.mode = 1'b0; if4.seed = '0; if4.resp_in = '0;
        if2.start = 1'b0; if2.mode = 1'b0; if2.seed = '0; if2.resp_in = '0;
        if1.start = 1'b0; if1.mode = 1'b0; if1.seed = '0; if1.resp_in = '0;
        test_reset();
        test_toggle();
        test_busy_start();
        test_lfsr();
        test_single();
        test_reset_midrun();
        test_start_rst_same();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/c432_stim_drv.md
Name: c432_stim_drv

Overview:
- Hardware stimulus transmitter and response compactor for the registered c432 harness (36 inputs, 7 outputs, one flop stage on each side).
- Drives the 36 harness inputs with a deterministic vector stream: either the bench's toggle-divider pattern or an LFSR sequence.
- Tracks the harness's 2-cycle pipeline and folds each returned 7-bit response into a 16-bit MISR signature.
- Sits beside the harness in self-test builds and replaces the behavioural testbench drivers.

Parameters:
- NUM_VEC, 2048: number of vectors per run, range 1..65535.
- PIPE_LAT, 2: harness flop stages between vec_out and resp_in.
- SEED_DFLT, 36'hF_FFFF_FFFF: LFSR seed used when the seed input is zero.
- GOLDEN_SIG, 16'h0000: expected signature, used only with the optional feature.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle request to begin a run; ignored unless IDLE.
- mode, in, 1: 0 = toggle-divider, 1 = LFSR; sampled at start.
- seed, in, 36: LFSR seed; sampled at start.
- vec_out, out, 36: harness input vector; bit0 = N1 … bit35 = N115.
- vec_valid, out, 1: vec_out holds a counted vector.
- resp_in, in, 7: harness outputs {N432,N431,N430,N421,N370,N329,N223}, bit0 = N223.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: one-cycle pulse when the signature is final.
- signature, out, 16: MISR value; holds after done until the next start.
- vec_count, out, 16: number of vectors issued in the current run.
- pass, out, 1: signature equals GOLDEN_SIG (optional feature).

Behaviour:
- Reset, and values in IDLE: vec_out=0, vec_valid=0, busy=0, done=0, signature=0, vec_count=0, pass=0, pipeline valid shift register cleared. Reset mid-run aborts the run to IDLE at once; no done pulse.
- States:
  - IDLE → RUN when start=1. On that edge, latch mode/seed, clear signature, present vector 0 with vec_valid=1, vec_count=1.
  - RUN: issue one vector per cycle. After vector NUM_VEC-1 is presented → DRAIN; vec_valid=0 and vec_out holds its last value.
  - DRAIN: wait until the valid pipe is empty, then → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Toggle mode: vector n, bit i = floor(n/(36-i)) mod 2. Implemented with 36 per-bit half-period down-counters; vector 0 is all zeros.
- LFSR mode:
  - Vector 0 = seed, or SEED_DFLT if seed==0.
  - Next state: shift toward bit35, new bit0 = b35 ^ b24 (polynomial x^36+x^25+1). The all-zero state is never reached.
- Latency:
  - vec_valid feeds a PIPE_LAT-deep shift register.
  - The MISR absorbs resp_in on any edge where the last stage is 1. The response to the vector presented after edge k is absorbed at edge k+PIPE_LAT+1.
- MISR: sig' = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {9'b0, resp_in}.
- done timing: start sampled at edge e → done high in the cycle after edge e+NUM_VEC+PIPE_LAT.
- Boundaries:
  - start while busy or in DONE is ignored.
  - start and rst in the same cycle: rst wins.
  - NUM_VEC=1: RUN lasts one cycle.
  - vec_count saturates at NUM_VEC.

Optional Feature:
- Macro: C432_STIM_DRV_GOLDEN_EN.
- Defined: a 16-bit comparator sets pass=(signature==GOLDEN_SIG) on the DONE edge. pass holds until the next start or rst.
- Undefined: no comparator; pass tied to 0.

Decomposition:
- Package c432_stim_pkg holds:
  - NUM_IN=36, NUM_OUT=7;
  - MISR_POLY=16'h1021;
  - LFSR tap indices 35/24;
  - state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, c432_misr: clock, reset, clear, enable, 7-bit data, 16-bit signature. It is reused on the response side of other harnesses.

Test Plan:
- Toggle mode, NUM_VEC=4: vec_out sequence 36'h0_0000_0000, 36'h8_0000_0000, 36'h4_0000_0000, 36'hE_0000_0000. vec_count reaches 4; done pulses in the cycle after edge e+6.
- resp_in held at 7'h00, any mode, NUM_VEC=4: signature=16'h0000 at done.
- resp_in held at 7'h01, NUM_VEC=2: signature=16'h0003. With NUM_VEC=1: signature=16'h0001.
- LFSR mode, seed=0: vector 0 = 36'hF_FFFF_FFFF and vector 1 = 36'hF_FFFF_FFFE. With seed=36'h1, vector 1 = 36'h2.
- rst asserted in the cycle after vector 2: next cycle busy=0, vec_valid=0, signature=0, and no done pulse. A start pressed while busy produces no second run.
- With C432_STIM_DRV_GOLDEN_EN defined, GOLDEN_SIG=16'h0003, NUM_VEC=2, resp_in=7'h01: pass=1. The same run with resp_in=7'h02 gives pass=0.
